// File: rtl/aqfp_pkg.sv
// ---------------------------------------------------------------------------
// aqfp_pkg
// Shared definitions for the AQFP excitation generator:
//   state_t     - controller state encoding (IDLE, SETTLE_IN, RUN, FLUSH)
//   NPHASE      - number of excitation quarter-phases per full cycle
//   XPAT_TABLE  - xout pattern per quarter index q, packed 4 bits per entry
//   xpat()      - table lookup helper
// ---------------------------------------------------------------------------
package aqfp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE_IN = 2'd1,
        ST_RUN       = 2'd2,
        ST_FLUSH     = 2'd3
    } state_t;

    localparam int NPHASE = 4;

    // Entry q lives at bits [4q+3:4q]; q0=1001, q1=0011, q2=0110, q3=1100.
    // Bit k is set when (q-k) mod 4 is 0 or 1, so each phase is high for
    // two consecutive quarters and adjacent phases overlap by one quarter.
    localparam logic [NPHASE*4-1:0] XPAT_TABLE = {4'b1100, 4'b0110, 4'b0011, 4'b1001};

    function automatic logic [3:0] xpat(input logic [1:0] q);
        return XPAT_TABLE[{q, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/aqfp_phase_seq.sv
// ---------------------------------------------------------------------------
// aqfp_phase_seq
// Quarter-phase sequencer: a DIV-clock divider feeding a modulo-4 quarter
// counter q.
//   clock, reset : system clock, synchronous active-high reset
//   clr          : hold divider and q at zero (used outside RUN)
//   en           : advance the divider this clock
//   q            : registered quarter index
//   q_next       : value q takes at the next edge (lets the parent register
//                  xout in lockstep with q)
//   wrap         : high on the last clock of q=3, i.e. the edge that ends a
//                  full excitation cycle
// ---------------------------------------------------------------------------
module aqfp_phase_seq #(
    parameter int DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] q,
    output logic [1:0] q_next,
    output logic       wrap
);

    localparam int DW = $clog2(DIV + 1);

    logic [DW-1:0] r_div;
    logic [1:0]    r_q;
    logic          w_tick;

    assign w_tick = en && (r_div == DW'(DIV - 1));
    assign wrap   = w_tick && (r_q == 2'd3);
    assign q      = r_q;

    always_comb begin
        q_next = r_q;
        if (clr) begin
            q_next = 2'd0;
        end else if (w_tick) begin
            q_next = r_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_div <= '0;
            r_q   <= 2'd0;
        end else if (en) begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            r_q   <= q_next;
        end
    end

endmodule

// File: rtl/aqfp_excite_gen.sv
// ---------------------------------------------------------------------------
// aqfp_excite_gen
// Burst controller for an AQFP cell column: DC bias ramp-in, four-phase AC
// excitation for n_cycles full cycles (or until stop), DC-only flush, done.
//   clock, reset : system clock, synchronous active-high reset
//   start        : one-clock burst request, honoured only in IDLE
//   n_cycles     : burst length in full cycles (0 = continuous), latched on start
//   stop         : graceful stop, takes effect at the next cycle boundary
//   dcout        : DC bias enable
//   xout[3:0]    : excitation phases, bit k = phase k
//   phase[1:0]   : current quarter index q
//   cyc_cnt      : completed cycles in current/last burst (saturating)
//   busy         : high outside IDLE
//   done         : one-clock pulse on return to IDLE
//   dbg_state    : controller state, for observation only
// All outputs are registered.
//
// Handshake: start and stop are level samples on the rising edge; a start is
// accepted only on an edge where the controller is in IDLE and reset is low,
// and busy goes high on that same edge. No acknowledge is returned.
// ---------------------------------------------------------------------------
module aqfp_excite_gen
    import aqfp_pkg::*;
#(
    parameter int DIV    = 4,
    parameter int SETTLE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] n_cycles,
    input  logic        stop,
    output logic        dcout,
    output logic [3:0]  xout,
    output logic [1:0]  phase,
    output logic [15:0] cyc_cnt,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    localparam int SW = $clog2(SETTLE + 1);

    state_t        r_state;
    logic [SW-1:0] r_settle_cnt;
    logic          r_stop_latch;
    logic [15:0]   r_ncyc;
    logic [15:0]   r_cyc;
    logic          r_dcout;
    logic [3:0]    r_xout;
    logic          r_busy;
    logic          r_done;

    state_t        w_state_n;
    logic [SW-1:0] w_settle_n;
    logic          w_stop_n;
    logic [15:0]   w_ncyc_n;
    logic [15:0]   w_cyc_n;
    logic [15:0]   w_cyc_inc;
    logic          w_dcout_n;
    logic [3:0]    w_xout_n;
    logic          w_done_n;
    logic          w_settle_last;
    logic          w_stop_req;

    logic [1:0]    w_q;
    logic [1:0]    w_q_next;
    logic          w_wrap;

    aqfp_phase_seq #(.DIV(DIV)) u_seq (
        .clock  (clock),
        .reset  (reset),
        .clr    (r_state != ST_RUN),
        .en     (r_state == ST_RUN),
        .q      (w_q),
        .q_next (w_q_next),
        .wrap   (w_wrap)
    );

    assign w_cyc_inc     = (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;
    assign w_settle_last = (r_settle_cnt == SW'(SETTLE - 1));
    // A stop arriving on the boundary edge itself still counts.
    assign w_stop_req    = r_stop_latch || stop;

    always_comb begin
        w_state_n  = r_state;
        w_settle_n = r_settle_cnt;
        w_stop_n   = r_stop_latch;
        w_ncyc_n   = r_ncyc;
        w_cyc_n    = r_cyc;
        w_dcout_n  = 1'b1;
        w_xout_n   = 4'b0000;
        w_done_n   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dcout_n = 1'b0;
                w_stop_n  = 1'b0;
                if (start) begin
                    w_state_n  = ST_SETTLE_IN;
                    w_ncyc_n   = n_cycles;
                    w_cyc_n    = 16'd0;
                    w_settle_n = '0;
                    w_dcout_n  = 1'b1;
                end
            end
            ST_SETTLE_IN: begin
                if (stop) begin
                    w_state_n  = ST_FLUSH;
                    w_settle_n = '0;
                end else if (w_settle_last) begin
                    w_state_n = ST_RUN;
                    w_xout_n  = xpat(2'd0);
                end else begin
                    w_settle_n = r_settle_cnt + SW'(1);
                end
            end
            ST_RUN: begin
                w_stop_n = w_stop_req;
                w_xout_n = xpat(w_q_next);
                if (w_wrap) begin
                    w_cyc_n = w_cyc_inc;
                    if (w_stop_req || ((r_ncyc != 16'd0) && (w_cyc_inc == r_ncyc))) begin
                        w_state_n  = ST_FLUSH;
                        w_settle_n = '0;
                        w_stop_n   = 1'b0;
                        w_xout_n   = 4'b0000;
                    end
                end
            end
            default: begin // ST_FLUSH
                if (w_settle_last) begin
                    w_state_n = ST_IDLE;
                    w_dcout_n = 1'b0;
                    w_done_n  = 1'b1;
                end else begin
                    w_settle_n = r_settle_cnt + SW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_stop_latch <= 1'b0;
            r_ncyc       <= 16'd0;
            r_cyc        <= 16'd0;
            r_dcout      <= 1'b0;
            r_xout       <= 4'b0000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_settle_cnt <= w_settle_n;
            r_stop_latch <= w_stop_n;
            r_ncyc       <= w_ncyc_n;
            r_cyc        <= w_cyc_n;
            r_dcout      <= w_dcout_n;
            r_xout       <= w_xout_n;
            r_busy       <= (w_state_n != ST_IDLE);
            r_done       <= w_done_n;
        end
    end

    assign dcout     = r_dcout;
    assign xout      = r_xout;
    assign phase     = w_q;
    assign cyc_cnt   = r_cyc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aqfp_excite_gen.sv
// ---------------------------------------------------------------------------
// tb_aqfp_excite_gen
// Bench for aqfp_excite_gen. Instance a uses DIV=4/SETTLE=16, instance b uses
// DIV=1/SETTLE=1. Each burst's per-clock output trace is pushed to exp_q when
// start is driven and popped on every falling edge.
// Trace word: {done, busy, dcout, xout[3:0], phase[1:0]}.
// ---------------------------------------------------------------------------
module tb_aqfp_excite_gen;

    logic clock = 1'b0;
    logic reset;

    logic        a_start, a_stop;
    logic [15:0] a_ncyc;
    logic        a_dcout, a_busy, a_done;
    logic [3:0]  a_xout;
    logic [1:0]  a_phase, a_dbg;
    logic [15:0] a_cyc;

    logic        b_start, b_stop;
    logic [15:0] b_ncyc;
    logic        b_dcout, b_busy, b_done;
    logic [3:0]  b_xout;
    logic [1:0]  b_phase, b_dbg;
    logic [15:0] b_cyc;

    int n_total = 0;
    int n_pass  = 0;
    int sel     = 0;
    int tcount  = 0;

    logic [8:0] exp_q[$];

    always #5 clock = ~clock;

    aqfp_excite_gen #(.DIV(4), .SETTLE(16)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .n_cycles(a_ncyc), .stop(a_stop),
        .dcout(a_dcout), .xout(a_xout), .phase(a_phase), .cyc_cnt(a_cyc),
        .busy(a_busy), .done(a_done), .dbg_state(a_dbg)
    );

    aqfp_excite_gen #(.DIV(1), .SETTLE(1)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .n_cycles(b_ncyc), .stop(b_stop),
        .dcout(b_dcout), .xout(b_xout), .phase(b_phase), .cyc_cnt(b_cyc),
        .busy(b_busy), .done(b_done), .dbg_state(b_dbg)
    );

    typedef struct {
        int          dut;        // 0 = a, 1 = b
        logic [15:0] ncyc;
        int          stop_at;    // ticks after start when stop pulses (-1 none)
        int          repulse_at; // ticks after start when start re-pulses (-1 none)
        int          settle_clks;
        int          run_cycles;
        logic [15:0] exp_cyc;
    } vec_t;

    vec_t vec[7];

    // Phase k is high when (q-k) mod 4 is 0 or 1.
    function automatic logic [3:0] ref_pat(input int q);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) p[k] = (((q - k + 4) % 4) < 2);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d actual=%h expected=%h", name, tcount, act, exp);
    endtask

    task automatic tick();
        logic [8:0] act;
        @(negedge clock);
        tcount++;
        act = (sel == 0) ? {a_done, a_busy, a_dcout, a_xout, a_phase}
                         : {b_done, b_busy, b_dcout, b_xout, b_phase};
        if (exp_q.size() > 0) check("trace", 32'(act), 32'(exp_q.pop_front()));
        check("x_needs_dc", 32'((act[5:2] != 4'b0) && !act[6]), 32'd0);
    endtask

    task automatic gen_burst(input int settle_clks, input int settle_par, input int div,
                             input int run_cycles);
        for (int i = 0; i < settle_clks; i++) exp_q.push_back({1'b0, 1'b1, 1'b1, 4'b0000, 2'd0});
        for (int c = 0; c < run_cycles; c++)
            for (int q = 0; q < 4; q++)
                for (int d = 0; d < div; d++)
                    exp_q.push_back({1'b0, 1'b1, 1'b1, ref_pat(q), 2'(q)});
        for (int i = 0; i < settle_par; i++) exp_q.push_back({1'b0, 1'b1, 1'b1, 4'b0000, 2'd0});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 4'b0000, 2'd0});
        exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0000, 2'd0});
    endtask

    task automatic set_in(input logic st, input logic [15:0] n, input logic sp);
        if (sel == 0) begin
            a_start = st; a_ncyc = n; a_stop = sp;
        end else begin
            b_start = st; b_ncyc = n; b_stop = sp;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cnt;
        int sp, dv;
        sel = v.dut;
        sp  = (v.dut == 0) ? 16 : 1;
        dv  = (v.dut == 0) ? 4 : 1;
        gen_burst(v.settle_clks, sp, dv, v.run_cycles);
        set_in(1'b1, v.ncyc, 1'b0);
        tick();
        cnt = 1;
        while (exp_q.size() > 0) begin
            if (cnt == v.repulse_at) set_in(1'b1, 16'd1, 1'b0);
            else set_in(1'b0, (cnt > v.repulse_at && v.repulse_at > 0) ? 16'd7 : v.ncyc,
                        (cnt == v.stop_at));
            tick();
            cnt++;
        end
        set_in(1'b0, 16'd0, 1'b0);
        check("cyc_cnt", 32'((sel == 0) ? a_cyc : b_cyc), 32'(v.exp_cyc));
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_stop = 1'b0; a_ncyc = 16'd0;
        b_start = 1'b0; b_stop = 1'b0; b_ncyc = 16'd0;

        vec[0] = '{0, 16'd2, -1, -1, 16, 2, 16'd2};
        vec[1] = '{0, 16'd0, 38, -1, 16, 2, 16'd2};
        vec[2] = '{0, 16'd0, 5, -1, 5, 0, 16'd0};
        vec[3] = '{0, 16'd3, -1, 25, 16, 3, 16'd3};
        vec[4] = '{0, 16'd1, -1, -1, 16, 1, 16'd1};
        vec[5] = '{1, 16'd1, -1, -1, 1, 1, 16'd1};
        vec[6] = '{1, 16'd3, -1, -1, 1, 3, 16'd3};

        repeat (3) @(posedge clock);
        tick();
        reset = 1'b0;
        check("rst_a", 32'({a_done, a_busy, a_dcout, a_xout, a_phase, a_cyc}), 32'd0);
        check("rst_b", 32'({b_done, b_busy, b_dcout, b_xout, b_phase, b_cyc}), 32'd0);

        // stop while idle must not do anything
        sel = 0;
        set_in(1'b0, 16'd0, 1'b1);
        exp_q.push_back(9'd0);
        exp_q.push_back(9'd0);
        tick();
        set_in(1'b0, 16'd0, 1'b0);
        tick();

        for (int i = 0; i < 7; i++) run_vec(vec[i]);

        // reset mid-RUN at q=2 with a stop latched and start on the same edge
        sel = 0;
        gen_burst(16, 16, 4, 1);
        set_in(1'b1, 16'd0, 1'b0);
        tick();
        for (int c = 1; c < 25; c++) begin
            set_in(1'b0, 16'd0, (c >= 22));
            tick();
        end
        check("q2_before_reset", 32'(a_phase), 32'd2);
        exp_q.delete();
        reset = 1'b1;
        set_in(1'b1, 16'd5, 1'b0);
        exp_q.push_back(9'd0);
        tick();
        check("reset_cyc", 32'(a_cyc), 32'd0);
        reset = 1'b0;
        set_in(1'b0, 16'd0, 1'b0);
        exp_q.push_back(9'd0);
        tick();
        check("reset_busy", 32'(a_busy), 32'd0);

        // normal burst after reset; a stuck stop latch would end it early
        run_vec('{0, 16'd2, -1, -1, 16, 2, 16'd2});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
